// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with 3-sample majority vote per bit, noise,
// framing and overrun detection, runtime baud divisor and a receive FIFO
// that stores status alongside each word.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one parity bit follows the data bits; per-entry pe output
//   undefined -> frame is start + DATA_BITS + stop; no pe port
//
// States:
//   S_IDLE   | waiting for a 1->0 edge on the synchronised line
//   S_START  | start bit; a majority of 1 is a false start
//   S_DATA   | shifting in DATA_BITS bits, LSB first
//   S_PARITY | single parity bit (parity build only)
//   S_STOP   | stop bit(s); completes at the last stop bit's final sample
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     baudrate,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 dr,
    output logic                 nf,
    output logic                 fe,
`ifdef UART_RX_PARITY_EN
    output logic                 over,
    output logic                 pe
`else
    output logic                 over
`endif
);

    localparam int               AW        = $clog2(FIFO_DEPTH);
    localparam int               BCW       = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(4);
    localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BCW-1:0]   LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    // Reject parameter values the datapath widths were not sized for.
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV_W < 3) begin : g_param_check
        $error("uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rxs, rxs_d;
    logic [DIV_W-1:0]     div, sc, sc_n, half, baud_eff;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic [1:0]           samp;
    logic                 at_s0, at_s1, at_eval, sc_last;
    logic                 maj, noisy;
    logic                 latch_div, frame_clr, shift_en, nf_set, fe_set, push;
    logic [DATA_BITS-1:0] shreg;
    logic                 f_nf, f_fe;
`ifdef UART_RX_PARITY_EN
    logic                 pe_chk, f_pe, exp_par;
    logic                 mem_pe [FIFO_DEPTH];
`endif

    logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
    logic                 mem_nf   [FIFO_DEPTH];
    logic                 mem_fe   [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, do_pop, do_wr, drop;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign baud_eff = (baudrate < DIV_MIN) ? DIV_MIN : baudrate;
    assign half     = div >> 1;
    assign at_s0    = (sc == half - DIV_W'(1));
    assign at_s1    = (sc == half);
    assign at_eval  = (sc == half + DIV_W'(1));
    assign sc_last  = (sc == div - DIV_W'(1));
    // The third sample is the live synced value in the evaluation cycle.
    assign maj      = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
    assign noisy    = !((samp[0] == samp[1]) && (samp[1] == rxs));

    // FSM state and bit-timing counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sc       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            state    <= state_n;
            sc       <= sc_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_n    = state;
        sc_n       = sc_last ? '0 : sc + DIV_W'(1);
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        latch_div  = 1'b0;
        frame_clr  = 1'b0;
        shift_en   = 1'b0;
        nf_set     = 1'b0;
        fe_set     = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_chk     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                sc_n = '0;
                if (rxs_d && !rxs) begin
                    state_n   = S_START;
                    latch_div = 1'b1;
                    frame_clr = 1'b1;
                end
            end
            S_START: begin
                bit_cnt_n = '0;
                if (sc_last) state_n = S_DATA;
                if (at_eval) begin
                    if (maj) begin
                        state_n = S_IDLE;
                        sc_n    = '0;
                    end else begin
                        nf_set = noisy;
                    end
                end
            end
            S_DATA: begin
                if (at_eval) begin
                    shift_en = 1'b1;
                    nf_set   = noisy;
                end
                if (sc_last) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n  = '0;
                        stop_cnt_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_n    = S_PARITY;
`else
                        state_n    = S_STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + BCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_eval) begin
                    pe_chk = 1'b1;
                    nf_set = noisy;
                end
                if (sc_last) begin
                    state_n    = S_STOP;
                    stop_cnt_n = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (sc_last) stop_cnt_n = stop_cnt + 1'b1;
                if (at_eval) begin
                    nf_set = noisy;
                    fe_set = !maj;
                    // Finish early so a start edge right after the stop bit is caught.
                    if (stop_cnt == LAST_STOP) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                        sc_n    = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                sc_n    = '0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign exp_par = (^shreg) ^ (PARITY_ODD != 0);
`endif

    // Frame datapath: divisor latch, sample capture, shift register, frame flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= DIV_MIN;
            samp  <= 2'b11;
            shreg <= '0;
            f_nf  <= 1'b0;
            f_fe  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            f_pe  <= 1'b0;
`endif
        end else begin
            if (latch_div) div <= baud_eff;
            if (at_s0) samp[0] <= rxs;
            if (at_s1) samp[1] <= rxs;
            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (frame_clr) begin
                f_nf <= 1'b0;
                f_fe <= 1'b0;
`ifdef UART_RX_PARITY_EN
                f_pe <= 1'b0;
`endif
            end else begin
                if (nf_set) f_nf <= 1'b1;
                if (fe_set) f_fe <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if (pe_chk) f_pe <= maj ^ exp_par;
`endif
            end
        end
    end

    assign full   = (count == FULL_CNT);
    assign do_pop = rd && (count != '0);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign do_wr  = push && (!full || do_pop);
    assign drop   = push && full && !do_pop;

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            over   <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) over <= 1'b1;
        end
    end

    // FIFO storage; the flags of the completing cycle are folded in here.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_data[wr_ptr] <= shreg;
            mem_nf[wr_ptr]   <= f_nf | nf_set;
            mem_fe[wr_ptr]   <= f_fe | fe_set;
`ifdef UART_RX_PARITY_EN
            mem_pe[wr_ptr]   <= f_pe;
`endif
        end
    end

    assign dr      = (count != '0);
    assign dataout = dr ? mem_data[rd_ptr] : '0;
    assign nf      = dr ? mem_nf[rd_ptr] : 1'b0;
    assign fe      = dr ? mem_fe[rd_ptr] : 1'b0;
`ifdef UART_RX_PARITY_EN
    assign pe      = dr ? mem_pe[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: drives serial frames bit by bit, keeps the
// expected FIFO contents in a queue, and compares every popped entry in a
// separate monitor. Honours UART_RX_PARITY_EN if it is defined.
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SB    = 1;
    localparam int PODD  = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PB    = 1;
`else
    localparam int PB    = 0;
`endif
    localparam int NB    = 1 + DB + PB + SB;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [DW-1:0] baudrate;
    logic          rd;
    logic [DB-1:0] dataout;
    logic          dr, nf, fe, over;
`ifdef UART_RX_PARITY_EN
    logic          pe;
`endif

    typedef struct {
        logic [DB-1:0] d;
        logic          nf;
        logic          fe;
        logic          pe;
    } exp_t;

    exp_t exp_q[$];
    logic exp_over;
    int   tests = 0;
    int   fails = 0;

    uart_rx_fifo #(
        .DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(DEPTH),
        .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .baudrate(baudrate), .rd(rd),
        .dataout(dataout), .dr(dr), .nf(nf), .fe(fe),
`ifdef UART_RX_PARITY_EN
        .over(over), .pe(pe)
`else
        .over(over)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop is compared against the head of the model.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && rd && dr) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got 0x%0h expected no entry", dataout);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", 32'(dataout), 32'(e.d));
                check("pop_nf", 32'(nf), 32'(e.nf));
                check("pop_fe", 32'(fe), 32'(e.fe));
`ifdef UART_RX_PARITY_EN
                check("pop_pe", 32'(pe), 32'(e.pe));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame at div clocks per bit. glitch_bit >= 0 flips the middle
    // sample of that frame bit (0 = start bit). Completion is expected at
    // 3 + (NB-1)*div + half + 1 cycles after the first start-bit cycle:
    // 2 synchroniser cycles, 1 edge-detect cycle, then the sample point.
    task automatic send_frame(input logic [DB-1:0] data, input int div, input int glitch_bit,
                              input bit bad_stop, input bit par_flip,
                              input bit rd_at_done, input bit chk_timing);
        logic bits [NB];
        exp_t e;
        int   half, c_done, n;
        half   = div / 2;
        c_done = 3 + (NB - 1) * div + half + 1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = data[i];
        if (PB == 1) bits[1+DB] = (^data) ^ PODD[0] ^ par_flip;
        for (int i = 0; i < SB; i++) bits[1+DB+PB+i] = !bad_stop;
        baudrate = DW'(div);
        n = 0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < div; k++) begin
                rx = (b == glitch_bit && k == 1 + half) ? !bits[b] : bits[b];
                if (chk_timing && n == c_done)     check("dr_before_done", 32'(dr), 32'd0);
                if (chk_timing && n == c_done + 1) check("dr_after_done", 32'(dr), 32'd1);
                if (rd_at_done && n == c_done)     rd = 1'b1;
                if (rd_at_done && n == c_done + 1) rd = 1'b0;
                tick();
                n++;
            end
        end
        rx = 1'b1;
        rd = 1'b0;
        e.d  = data;
        e.nf = (glitch_bit >= 0);
        e.fe = bad_stop;
        e.pe = par_flip;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_over = 1'b1;
        repeat (4) tick();
    endtask

    task automatic read_one();
        int t;
        t = 0;
        while (!dr && t < 50) begin
            tick();
            t++;
        end
        if (!dr) begin
            check("read_timeout_dr", 32'(dr), 32'd1);
        end else begin
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) read_one();
        tick();
        check("empty_dr", 32'(dr), 32'd0);
        check("empty_dataout", 32'(dataout), 32'd0);
        check("empty_flags", 32'({nf, fe}), 32'd0);
    endtask

    initial begin
        int div, gb;
        bit bs, pf;
        logic [DB-1:0] d;

        reset    = 1'b1;
        rx       = 1'b1;
        rd       = 1'b0;
        baudrate = DW'(16);
        exp_over = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_dr", 32'(dr), 32'd0);
        check("reset_dataout", 32'(dataout), 32'd0);
        check("reset_nf", 32'(nf), 32'd0);
        check("reset_fe", 32'(fe), 32'd0);
        check("reset_over", 32'(over), 32'd0);

        // Clean frame with completion timing.
        send_frame(8'hA5, 16, -1, 0, 0, 0, 1);
        drain();
        check("clean_over", 32'(over), 32'd0);

        // False start: line low for three clocks only.
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (40) tick();
        check("false_start_dr", 32'(dr), 32'd0);
        send_frame(8'h5A, 16, -1, 0, 0, 0, 0);
        drain();

        // Noisy middle sample in data bit 3.
        send_frame(8'h3C, 16, 4, 0, 0, 0, 0);
        drain();

        // Framing error, then a good frame.
        send_frame(8'h55, 16, -1, 1, 0, 0, 0);
        send_frame(8'h0F, 16, -1, 0, 0, 0, 0);
        drain();

        // Fill the FIFO; a pop in the completion cycle avoids the overrun.
        for (int i = 1; i <= DEPTH; i++) send_frame(DB'(i), 16, -1, 0, 0, 0, 0);
        check("full_dr", 32'(dr), 32'd1);
        send_frame(DB'(DEPTH + 1), 16, -1, 0, 0, 1, 0);
        check("pop_push_over", 32'(over), 32'(exp_over));
        send_frame(DB'(DEPTH + 2), 16, -1, 0, 0, 0, 0);
        check("overrun_over", 32'(over), 32'(exp_over));
        drain();
        check("overrun_sticky", 32'(over), 32'd1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 16, -1, 0, 0, 0, 0);
        send_frame(8'h07, 16, -1, 0, 1, 0, 0);
        drain();
`endif

        // Reset in the middle of the data bits of a frame, with a stored entry.
        send_frame(8'h33, 16, -1, 0, 0, 0, 0);
        rx = 1'b0;
        repeat (16) tick();
        rx = 1'b1;
        repeat (16) tick();
        rx = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        exp_over = 1'b0;
        tick();
        check("midreset_dr", 32'(dr), 32'd0);
        check("midreset_dataout", 32'(dataout), 32'd0);
        check("midreset_flags", 32'({nf, fe}), 32'd0);
        check("midreset_over", 32'(over), 32'd0);
        send_frame(8'h81, 16, -1, 0, 0, 0, 0);
        drain();

        // Randomised frames, divisors, glitches, framing errors and read timing.
        for (int i = 0; i < 16; i++) begin
            d   = DB'($urandom);
            div = int'($urandom_range(6, 24));
            gb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            bs  = ($urandom_range(0, 4) == 0);
            pf  = (PB == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
            send_frame(d, div, gb, bs, pf, 0, 0);
            check("rand_over", 32'(over), 32'(exp_over));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        check("final_over", 32'(over), 32'(exp_over));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
